keccak_padder: RTL and testbench

- Upstream neighbour of the Keccak f-permutation stage in the low-throughput SHA-3 core.
- Accepts the message as a stream of 64-bit words with byte-granular final length.
- Applies multi-rate padding (domain byte, zero fill, final 0x80) and packs the result into 576-bit rate blocks (9 words).
- Presents each block on out/out_ready and holds it until the permutation stage pulses f_ack.

---
 rtl/keccak_pkg.sv | 25 ++
 rtl/pad_word.sv | 28 ++
 rtl/keccak_padder.sv | 97 +++++++++
 tb/tb_keccak_padder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared constants for the SHA-3 padder slice.
//   - Rate block geometry: 576-bit blocks made of nine 64-bit words.
//   - Padding bytes: default domain/first pad byte and the final-bit mask.
//   - Padder FSM state encodings, kept as plain constants so older code can compare against them.
package keccak_pkg;

   localparam int WORD_W     = 64;
   localparam int RATE_WORDS = 9;
   localparam int RATE_BITS  = WORD_W * RATE_WORDS;   // 576

   localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h01;
   localparam logic [7:0] FINAL_BIT        = 8'h80;

   // Word counter: 0..9, where 9 means a full block is held.
   localparam int         CNT_W    = 4;
   localparam logic [3:0] CNT_FULL = 4'(RATE_WORDS);
   localparam logic [3:0] CNT_LAST = 4'(RATE_WORDS - 1);

   // Padder FSM states.
   typedef logic [1:0] state_t;
   localparam state_t ACCEPT = 2'd0;   // taking message words
   localparam state_t PAD    = 2'd1;   // filling the final block with zero words
   localparam state_t DONE   = 2'd2;   // final block consumed; idle until reset

endpackage

// File: rtl/pad_word.sv
// Builds the final message word of a message.
//   in       : last message word, byte k at in[63-8k -: 8].
//   byte_num : number of valid message bytes in the word (0..7).
//   out      : bytes below byte_num pass through, byte byte_num becomes
//              PAD_BYTE, and every later byte is zero.
// Purely combinational.
module pad_word
   import keccak_pkg::*;
#(
   parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
   input  logic [WORD_W-1:0] in,
   input  logic [2:0]        byte_num,
   output logic [WORD_W-1:0] out
);

   always_comb begin
      out = '0;
      for (int k = 0; k < 8; k++) begin
         if (k < int'(byte_num)) begin
            out[63-8*k -: 8] = in[63-8*k -: 8];
         end else if (k == int'(byte_num)) begin
            out[63-8*k -: 8] = PAD_BYTE;
         end
      end
   end

endmodule

// File: rtl/keccak_padder.sv
// Keccak multi-rate padder and block packer. It sits in front of the
// f-permutation stage of the low-throughput SHA-3 core.
//
// Ports:
//   clk, reset   : clock and synchronous active-high reset.
//   in           : 64-bit message word. Byte 0 (first in message order) is in[63:56].
//   in_ready     : in/is_last/byte_num are valid this cycle.
//   is_last      : this word ends the message.
//   byte_num     : valid bytes in the last word (0..7). Ignored unless is_last is set.
//   buffer_full  : the padder cannot take a word this cycle.
//   out          : 576-bit rate block. The first word is in out[575:512].
//   out_ready    : out holds a complete padded block.
//   f_ack        : one-cycle pulse from downstream; the block has been consumed.
//   dbg_state    : current FSM state (ACCEPT/PAD/DONE).
//   dbg_cnt      : current word count (0..9).
//
// Handshake: a word transfers on a rising edge where in_ready=1 and
// buffer_full=0. buffer_full depends only on registers, so the upstream
// block may look at it before it decides to drive in_ready. A block is
// handed off on an edge where out_ready=1 and f_ack=1. The padder ignores
// f_ack while out_ready=0, and out does not change while out_ready=1.
module keccak_padder
   import keccak_pkg::*;
#(
   parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_W-1:0]    in,
   input  logic                 in_ready,
   input  logic                 is_last,
   input  logic [2:0]           byte_num,
   output logic                 buffer_full,
   output logic [RATE_BITS-1:0] out,
   output logic                 out_ready,
   input  logic                 f_ack,
   output state_t               dbg_state,
   output logic [CNT_W-1:0]     dbg_cnt
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WORD_W-1:0]  padded;
   logic [WORD_W-1:0]  load_word;
   logic               load_en;
   logic               accept;

   pad_word #(.PAD_BYTE(PAD_BYTE)) u_pad_word (
      .in       (in),
      .byte_num (byte_num),
      .out      (padded)
   );

   assign out_ready   = (cnt == CNT_FULL);
   assign buffer_full = out_ready | (state != ACCEPT);
   assign accept      = in_ready & ~buffer_full;
   assign dbg_state   = state;
   assign dbg_cnt     = cnt;

   // Choose the word that enters the block this cycle. It is either a
   // message word (accepted in ACCEPT) or a zero fill word (in PAD). When
   // that word fills slot 8 of the final block, the final bit goes into
   // its lowest byte. A last word that lands in slot 8 already holds
   // PAD_BYTE at byte 7 if byte_num was 7, so both bits merge into one byte.
   always_comb begin
      load_en   = 1'b0;
      load_word = '0;
      if (state == ACCEPT && accept) begin
         load_en   = 1'b1;
         load_word = is_last ? padded : in;
      end else if (state == PAD && cnt < CNT_FULL) begin
         load_en   = 1'b1;
      end
      if (load_en && cnt == CNT_LAST && (state == PAD || is_last)) begin
         load_word[7:0] = load_word[7:0] | FINAL_BIT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out   <= '0;
         cnt   <= '0;
         state <= ACCEPT;
      end else if (load_en) begin
         out <= {out[RATE_BITS-WORD_W-1:0], load_word};
         cnt <= cnt + 4'd1;
         if (state == ACCEPT && is_last) begin
            state <= PAD;
         end
      end else if (out_ready && f_ack) begin
         // A block acked while in PAD is the padded final block.
         cnt   <= '0;
         state <= (state == PAD) ? DONE : ACCEPT;
      end
   end

endmodule

// File: tb/tb_keccak_padder.sv
module tb_keccak_padder;
   import keccak_pkg::*;

   // ---------------- clock / reset ----------------
   logic                 clk = 1'b0;
   logic                 reset;
   logic [63:0]          in_w;
   logic                 in_ready;
   logic                 is_last;
   logic [2:0]           byte_num;
   logic                 buffer_full;
   logic [575:0]         out;
   logic                 out_ready;
   logic                 f_ack;
   state_t               dbg_state;
   logic [3:0]           dbg_cnt;

   always #5 clk = ~clk;

   keccak_padder dut (
      .clk         (clk),
      .reset       (reset),
      .in          (in_w),
      .in_ready    (in_ready),
      .is_last     (is_last),
      .byte_num    (byte_num),
      .buffer_full (buffer_full),
      .out         (out),
      .out_ready   (out_ready),
      .f_ack       (f_ack),
      .dbg_state   (dbg_state),
      .dbg_cnt     (dbg_cnt)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [575:0] exp_q[$];

   task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after a rising edge. Outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic send_word(input string tag, input logic [63:0] w, input logic last, input logic [2:0] bn);
      check({tag, "_not_full"}, {575'b0, buffer_full}, 576'd0);
      in_w = w; in_ready = 1'b1; is_last = last; byte_num = bn;
      tick();
      in_ready = 1'b0; is_last = 1'b0; byte_num = 3'd0; in_w = '0;
   endtask

   task automatic ack();
      f_ack = 1'b1;
      tick();
      f_ack = 1'b0;
   endtask

   // Wait (bounded) for out_ready, then compare the block with the scoreboard head.
   task automatic expect_block(input string tag);
      int waited = 0;
      while (!out_ready && waited < 30) begin
         tick();
         waited++;
      end
      if (!out_ready) begin
         check({tag, "_timeout"}, 576'd0, 576'd1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
         check({tag, "_no_expected"}, 576'd0, 576'd1);
      end else begin
         check(tag, out, exp_q.pop_front());
      end
   endtask

   task automatic check_done(input string tag);
      check({tag, "_state_done"}, {574'b0, dbg_state}, {574'b0, DONE});
      check({tag, "_full_done"}, {575'b0, buffer_full}, 576'd1);
      check({tag, "_cnt_done"}, {572'b0, dbg_cnt}, 576'd0);
      // Input offered in DONE must be ignored.
      in_w = 64'hFFFF_FFFF_FFFF_FFFF; in_ready = 1'b1; is_last = 1'b1;
      tick(); tick();
      in_ready = 1'b0; is_last = 1'b0;
      check({tag, "_ignore_cnt"}, {572'b0, dbg_cnt}, 576'd0);
      check({tag, "_ignore_ready"}, {575'b0, out_ready}, 576'd0);
      check({tag, "_ignore_full"}, {575'b0, buffer_full}, 576'd1);
   endtask

   // Expected block for an empty (or exactly word-aligned) final block.
   function automatic logic [575:0] empty_block();
      logic [575:0] e;
      e = '0;
      e[575:568] = 8'h01;
      e[7:0]     = 8'h80;
      return e;
   endfunction

   // ---------------- directed stimulus ----------------
   logic [63:0]  data_w [9];
   logic [575:0] e;

   initial begin
      data_w[0] = 64'h0011_2233_4455_6677;
      data_w[1] = 64'h8899_AABB_CCDD_EEFF;
      data_w[2] = 64'hDEAD_BEEF_CAFE_F00D;
      data_w[3] = 64'h0123_4567_89AB_CDEF;
      data_w[4] = 64'hFEDC_BA98_7654_3210;
      data_w[5] = 64'h1357_9BDF_2468_ACE0;
      data_w[6] = 64'hA5A5_5A5A_C3C3_3C3C;
      data_w[7] = 64'h0F0F_F0F0_1234_ABCD;
      data_w[8] = 64'h7777_8888_9999_AAAA;

      reset = 1'b1; in_w = '0; in_ready = 1'b0; is_last = 1'b0; byte_num = 3'd0; f_ack = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      check("rst_out", out, 576'd0);
      check("rst_out_ready", {575'b0, out_ready}, 576'd0);
      check("rst_full", {575'b0, buffer_full}, 576'd0);
      check("rst_cnt", {572'b0, dbg_cnt}, 576'd0);
      check("rst_state", {574'b0, dbg_state}, {574'b0, ACCEPT});

      // Empty message: 1 accept, then 8 pad cycles
      send_word("empty", 64'h0, 1'b1, 3'd0);
      check("empty_pad_state", {574'b0, dbg_state}, {574'b0, PAD});
      check("empty_pad_full", {575'b0, buffer_full}, 576'd1);
      for (int i = 0; i < 7; i++) tick();
      check("empty_latency_early", {575'b0, out_ready}, 576'd0);
      tick();
      check("empty_latency", {575'b0, out_ready}, 576'd1);
      exp_q.push_back(empty_block());
      expect_block("empty_block");
      tick(); tick();
      check("empty_stable", out, empty_block());
      ack();
      check_done("empty");

      // "abc", with junk in the ignored bytes
      do_reset();
      send_word("abc", 64'h6162_63DE_ADBE_EF55, 1'b1, 3'd3);
      e = '0;
      e[575:512] = 64'h6162_6301_0000_0000;
      e[7:0]     = 8'h80;
      exp_q.push_back(e);
      expect_block("abc_block");
      ack();
      check_done("abc");

      // 71 bytes: 8 full words plus 7 bytes in slot 8, giving 0x81
      do_reset();
      for (int i = 0; i < 8; i++) send_word("m71", data_w[i], 1'b0, 3'd0);
      check("m71_not_ready", {575'b0, out_ready}, 576'd0);
      send_word("m71_last", 64'h1122_3344_5566_7799, 1'b1, 3'd7);
      check("m71_latency", {575'b0, out_ready}, 576'd1);
      e = '0;
      for (int i = 0; i < 8; i++) e[575-64*i -: 64] = data_w[i];
      e[63:0] = 64'h1122_3344_5566_7781;
      exp_q.push_back(e);
      expect_block("m71_block");
      ack();
      check_done("m71");

      // 72 bytes: raw block, stalled ack, then an aligned padding block
      do_reset();
      for (int i = 0; i < 9; i++) send_word("m72", data_w[i], 1'b0, 3'd0);
      e = '0;
      for (int i = 0; i < 9; i++) e[575-64*i -: 64] = data_w[i];
      exp_q.push_back(e);
      expect_block("m72_block1");
      in_w = 64'hFFEE_DDCC_BBAA_9988; in_ready = 1'b1; is_last = 1'b1; byte_num = 3'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("m72_stall_full", {575'b0, buffer_full}, 576'd1);
         check("m72_stall_out", out, e);
         check("m72_stall_cnt", {572'b0, dbg_cnt}, 576'd9);
      end
      // f_ack and in_ready together: the word waits one cycle
      f_ack = 1'b1;
      tick();
      f_ack = 1'b0;
      check("m72_ack_cnt", {572'b0, dbg_cnt}, 576'd0);
      check("m72_ack_state", {574'b0, dbg_state}, {574'b0, ACCEPT});
      tick();
      in_ready = 1'b0; is_last = 1'b0;
      check("m72_capture_cnt", {572'b0, dbg_cnt}, 576'd1);
      check("m72_capture_word", {512'b0, out[63:0]}, {512'b0, 64'h0100_0000_0000_0000});
      exp_q.push_back(empty_block());
      expect_block("m72_block2");
      ack();
      check_done("m72");

      // Reset in the middle of a block
      do_reset();
      for (int i = 0; i < 5; i++) send_word("mid", data_w[i], 1'b0, 3'd0);
      check("mid_cnt5", {572'b0, dbg_cnt}, 576'd5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_cnt", {572'b0, dbg_cnt}, 576'd0);
      check("mid_rst_out", out, 576'd0);
      check("mid_rst_ready", {575'b0, out_ready}, 576'd0);
      check("mid_rst_full", {575'b0, buffer_full}, 576'd0);
      send_word("mid_empty", 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 3'd0);
      exp_q.push_back(empty_block());
      expect_block("mid_empty_block");
      ack();
      check_done("mid_empty");

      check("scoreboard_drained", 576'(exp_q.size()), 576'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
